// File: rtl/multicycle_sequencer_if.sv
// Control bundle between the PhilosophyV multicycle sequencer and the datapath/memory side.
// The slave modport is the sequencer; the master modport is the datapath or a bench driving it.
interface multicycle_sequencer_if #(
    parameter int OPCODE_WIDTH = 7,
    parameter int STATE_WIDTH  = 4
);
    logic [OPCODE_WIDTH-1:0] opCode;
    logic                    memReady;
    logic                    PCEna;
    logic                    IREna;
    logic                    IorD;
    logic                    memWrite;
    logic                    ALUSrcA;
    logic [1:0]              ALUSrcB;
    logic                    ALUUseFunct;
    logic                    regFileWrite;
    logic                    memToReg;
    logic                    instrRetired;
    logic                    trap;
    logic [STATE_WIDTH-1:0]  state;

    modport slave (
        input  opCode, memReady,
        output PCEna, IREna, IorD, memWrite, ALUSrcA, ALUSrcB, ALUUseFunct,
               regFileWrite, memToReg, instrRetired, trap, state
    );

    modport master (
        output opCode, memReady,
        input  PCEna, IREna, IorD, memWrite, ALUSrcA, ALUSrcB, ALUUseFunct,
               regFileWrite, memToReg, instrRetired, trap, state
    );
endinterface

// File: rtl/multicycle_sequencer.sv
// Multicycle control FSM for PhilosophyV: fetch/decode/execute/memory/writeback with memReady stalls.
// Optional: define PHILV_ILLEGAL_TRAP_EN to send illegal opcodes to a sticky TRAP state instead of a NOP.
module multicycle_sequencer #(
    parameter int OPCODE_WIDTH = 7,
    parameter int STATE_WIDTH  = 4
) (
    input logic                  clk,
    input logic                  rstb,
    multicycle_sequencer_if.slave bus
);

    typedef enum logic [STATE_WIDTH-1:0] {
        FETCH   = STATE_WIDTH'(0),
        DECODE  = STATE_WIDTH'(1),
        EXEC    = STATE_WIDTH'(2),
        MEM_RD  = STATE_WIDTH'(3),
        MEM_WR  = STATE_WIDTH'(4),
        ALU_WB  = STATE_WIDTH'(5),
        LOAD_WB = STATE_WIDTH'(6),
        TRAP    = STATE_WIDTH'(7)
    } state_t;

    localparam logic [OPCODE_WIDTH-1:0] OP_R     = OPCODE_WIDTH'(7'b0110011);
    localparam logic [OPCODE_WIDTH-1:0] OP_I     = OPCODE_WIDTH'(7'b0010011);
    localparam logic [OPCODE_WIDTH-1:0] OP_LOAD  = OPCODE_WIDTH'(7'b0000011);
    localparam logic [OPCODE_WIDTH-1:0] OP_STORE = OPCODE_WIDTH'(7'b0100011);

    state_t                  state_r;
    state_t                  state_s;
    logic [OPCODE_WIDTH-1:0] op_r;
    logic                    legal_s;

    logic       pc_ena_s;
    logic       ir_ena_s;
    logic       iord_s;
    logic       mem_write_s;
    logic       alu_src_a_s;
    logic [1:0] alu_src_b_s;
    logic       alu_use_funct_s;
    logic       reg_file_write_s;
    logic       mem_to_reg_s;
    logic       instr_retired_s;

    function automatic logic is_legal(input logic [OPCODE_WIDTH-1:0] op);
        logic legal;
        case (op)
            OP_R, OP_I, OP_LOAD, OP_STORE: legal = 1'b1;
            default:                       legal = 1'b0;
        endcase
        return legal;
    endfunction

    assign legal_s = is_legal(bus.opCode);

    // State register
    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            state_r <= FETCH;
        end else begin
            state_r <= state_s;
        end
    end

    // Opcode capture in DECODE so EXEC no longer depends on the IR input
    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            op_r <= '0;
        end else if (state_r == DECODE) begin
            op_r <= bus.opCode;
        end else begin
            op_r <= op_r;
        end
    end

`ifdef PHILV_ILLEGAL_TRAP_EN
    logic trap_r;

    // Sticky trap flag, cleared only by reset
    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            trap_r <= 1'b0;
        end else if (state_s == TRAP) begin
            trap_r <= 1'b1;
        end else begin
            trap_r <= trap_r;
        end
    end

    assign bus.trap = trap_r;
`else
    assign bus.trap = 1'b0;
`endif

    // Next-state logic
    always_comb begin
        state_s = state_r;
        case (state_r)
            FETCH: begin
                if (bus.memReady) state_s = DECODE;
                else              state_s = FETCH;
            end
            DECODE: begin
                if (legal_s) begin
                    state_s = EXEC;
                end else begin
`ifdef PHILV_ILLEGAL_TRAP_EN
                    state_s = TRAP;
`else
                    state_s = FETCH;
`endif
                end
            end
            EXEC: begin
                case (op_r)
                    OP_R, OP_I: state_s = ALU_WB;
                    OP_LOAD:    state_s = MEM_RD;
                    OP_STORE:   state_s = MEM_WR;
                    default:    state_s = FETCH;
                endcase
            end
            MEM_RD: begin
                if (bus.memReady) state_s = LOAD_WB;
                else              state_s = MEM_RD;
            end
            MEM_WR: begin
                if (bus.memReady) state_s = FETCH;
                else              state_s = MEM_WR;
            end
            ALU_WB:  state_s = FETCH;
            LOAD_WB: state_s = FETCH;
`ifdef PHILV_ILLEGAL_TRAP_EN
            TRAP:    state_s = TRAP;
`else
            TRAP:    state_s = FETCH;
`endif
            default: state_s = FETCH;
        endcase
    end

    // Moore decode of controls; FETCH outputs are also gated by rstb so nothing fires while held in reset
    always_comb begin
        pc_ena_s         = 1'b0;
        ir_ena_s         = 1'b0;
        iord_s           = 1'b0;
        mem_write_s      = 1'b0;
        alu_src_a_s      = 1'b0;
        alu_src_b_s      = 2'b00;
        alu_use_funct_s  = 1'b0;
        reg_file_write_s = 1'b0;
        mem_to_reg_s     = 1'b0;
        instr_retired_s  = 1'b0;
        case (state_r)
            FETCH: begin
                if (rstb) begin
                    alu_src_b_s = 2'b01;
                    pc_ena_s    = bus.memReady;
                    ir_ena_s    = bus.memReady;
                end else begin
                    alu_src_b_s = 2'b00;
                end
            end
            DECODE: begin
`ifdef PHILV_ILLEGAL_TRAP_EN
                instr_retired_s = 1'b0;
`else
                instr_retired_s = ~legal_s;
`endif
            end
            EXEC: begin
                alu_src_a_s = 1'b1;
                case (op_r)
                    OP_R: begin
                        alu_src_b_s     = 2'b00;
                        alu_use_funct_s = 1'b1;
                    end
                    OP_I: begin
                        alu_src_b_s     = 2'b10;
                        alu_use_funct_s = 1'b1;
                    end
                    OP_LOAD, OP_STORE: begin
                        alu_src_b_s     = 2'b10;
                        alu_use_funct_s = 1'b0;
                    end
                    default: begin
                        alu_src_b_s     = 2'b00;
                        alu_use_funct_s = 1'b0;
                    end
                endcase
            end
            MEM_RD: begin
                iord_s = 1'b1;
            end
            MEM_WR: begin
                iord_s          = 1'b1;
                mem_write_s     = 1'b1;
                instr_retired_s = bus.memReady;
            end
            ALU_WB: begin
                reg_file_write_s = 1'b1;
                instr_retired_s  = 1'b1;
            end
            LOAD_WB: begin
                reg_file_write_s = 1'b1;
                mem_to_reg_s     = 1'b1;
                instr_retired_s  = 1'b1;
            end
            TRAP: begin
                instr_retired_s = 1'b0;
            end
            default: begin
                instr_retired_s = 1'b0;
            end
        endcase
    end

    assign bus.PCEna        = pc_ena_s;
    assign bus.IREna        = ir_ena_s;
    assign bus.IorD         = iord_s;
    assign bus.memWrite     = mem_write_s;
    assign bus.ALUSrcA      = alu_src_a_s;
    assign bus.ALUSrcB      = alu_src_b_s;
    assign bus.ALUUseFunct  = alu_use_funct_s;
    assign bus.regFileWrite = reg_file_write_s;
    assign bus.memToReg     = mem_to_reg_s;
    assign bus.instrRetired = instr_retired_s;
    assign bus.state        = state_r;

endmodule

// File: tb/tb_multicycle_sequencer.sv
// Self-checking bench for multicycle_sequencer: per-cycle expected state/controls are queued as
// stimulus is driven and popped/compared at the following falling edge.
module tb_multicycle_sequencer;

    logic clk;
    logic rstb;

    multicycle_sequencer_if bus ();

    multicycle_sequencer dut (
        .clk  (clk),
        .rstb (rstb),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    localparam logic [6:0] OP_R = 7'b0110011;
    localparam logic [6:0] OP_I = 7'b0010011;
    localparam logic [6:0] OP_L = 7'b0000011;
    localparam logic [6:0] OP_S = 7'b0100011;
    localparam logic [6:0] OP_X = 7'b1111111;

    // {PCEna,IREna,IorD,memWrite,ALUSrcA,ALUSrcB[1:0],ALUUseFunct,regFileWrite,memToReg,instrRetired,trap}
    localparam logic [11:0] C_ZERO        = 12'b000000000000;
    localparam logic [11:0] C_FETCH_RDY   = 12'b110000100000;
    localparam logic [11:0] C_FETCH_STALL = 12'b000000100000;
    localparam logic [11:0] C_DECODE      = 12'b000000000000;
    localparam logic [11:0] C_DECODE_NOP  = 12'b000000000010;
    localparam logic [11:0] C_EXEC_R      = 12'b000010010000;
    localparam logic [11:0] C_EXEC_I      = 12'b000011010000;
    localparam logic [11:0] C_EXEC_MEM    = 12'b000011000000;
    localparam logic [11:0] C_MEMRD       = 12'b001000000000;
    localparam logic [11:0] C_MEMWR_STALL = 12'b001100000000;
    localparam logic [11:0] C_MEMWR_DONE  = 12'b001100000010;
    localparam logic [11:0] C_ALUWB       = 12'b000000001010;
    localparam logic [11:0] C_LOADWB      = 12'b000000001110;
    localparam logic [11:0] C_TRAP        = 12'b000000000001;

    typedef struct {
        string       tag;
        logic [3:0]  st;
        logic [11:0] ctl;
    } exp_t;

    exp_t sb_q[$];
    int   n_total;
    int   n_bad;

    logic [11:0] obs_ctl;
    assign obs_ctl = {bus.PCEna, bus.IREna, bus.IorD, bus.memWrite, bus.ALUSrcA, bus.ALUSrcB,
                      bus.ALUUseFunct, bus.regFileWrite, bus.memToReg, bus.instrRetired, bus.trap};

    task automatic check_val(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%h expected=%h", tag, got, exp);
        end
    endtask

    task automatic push_exp(input string tag, input logic [3:0] st, input logic [11:0] ctl);
        exp_t e;
        e.tag = tag;
        e.st  = st;
        e.ctl = ctl;
        sb_q.push_back(e);
    endtask

    task automatic compare_front();
        exp_t e;
        if (sb_q.size() == 0) begin
            check_val("scoreboard_empty", 16'd0, 16'd1);
        end else begin
            e = sb_q.pop_front();
            check_val({e.tag, ".state"}, {12'd0, bus.state}, {12'd0, e.st});
            check_val({e.tag, ".ctl"},   {4'd0, obs_ctl},    {4'd0, e.ctl});
        end
    endtask

    // One clock cycle: drive inputs, queue the expectation, compare at the falling edge.
    task automatic cyc(input string tag, input logic [6:0] op, input logic rdy,
                       input logic [3:0] est, input logic [11:0] ectl);
        bus.opCode   = op;
        bus.memReady = rdy;
        push_exp(tag, est, ectl);
        @(negedge clk);
        compare_front();
        @(posedge clk);
        #1;
    endtask

    initial begin
        n_total      = 0;
        n_bad        = 0;
        rstb         = 1'b0;
        bus.opCode   = 7'd0;
        bus.memReady = 1'b1;

        // Reset: memReady high must not leak onto the enables
        repeat (2) @(posedge clk);
        push_exp("reset", 4'd0, C_ZERO);
        @(negedge clk);
        compare_front();
        @(posedge clk);
        #1;
        rstb = 1'b1;

        // R-type add: 0,1,2,5
        cyc("r.fetch",  OP_X, 1'b1, 4'd0, C_FETCH_RDY);
        cyc("r.decode", OP_R, 1'b1, 4'd1, C_DECODE);
        cyc("r.exec",   OP_L, 1'b1, 4'd2, C_EXEC_R);
        cyc("r.wb",     OP_L, 1'b0, 4'd5, C_ALUWB);

        // I-ALU: 0,1,2,5
        cyc("i.fetch",  OP_R, 1'b1, 4'd0, C_FETCH_RDY);
        cyc("i.decode", OP_I, 1'b1, 4'd1, C_DECODE);
        cyc("i.exec",   OP_S, 1'b0, 4'd2, C_EXEC_I);
        cyc("i.wb",     OP_S, 1'b1, 4'd5, C_ALUWB);

        // LOAD with two stall cycles in MEM_RD: 0,1,2,3,3,3,6
        cyc("ld.fetch",  OP_X, 1'b1, 4'd0, C_FETCH_RDY);
        cyc("ld.decode", OP_L, 1'b0, 4'd1, C_DECODE);
        cyc("ld.exec",   OP_R, 1'b0, 4'd2, C_EXEC_MEM);
        cyc("ld.mem0",   OP_R, 1'b0, 4'd3, C_MEMRD);
        cyc("ld.mem1",   OP_R, 1'b0, 4'd3, C_MEMRD);
        cyc("ld.mem2",   OP_R, 1'b1, 4'd3, C_MEMRD);
        cyc("ld.wb",     OP_R, 1'b0, 4'd6, C_LOADWB);

        // STORE, no stall: 0,1,2,4
        cyc("st.fetch",  OP_X, 1'b1, 4'd0, C_FETCH_RDY);
        cyc("st.decode", OP_S, 1'b1, 4'd1, C_DECODE);
        cyc("st.exec",   OP_R, 1'b0, 4'd2, C_EXEC_MEM);
        cyc("st.mem",    OP_R, 1'b1, 4'd4, C_MEMWR_DONE);

        // FETCH stall of 3, then a STORE that stalls twice in MEM_WR
        for (int i = 0; i < 3; i++) begin
            cyc("fs.stall", OP_S, 1'b0, 4'd0, C_FETCH_STALL);
        end
        cyc("fs.fetch",  OP_S, 1'b1, 4'd0, C_FETCH_RDY);
        cyc("fs.decode", OP_S, 1'b1, 4'd1, C_DECODE);
        cyc("fs.exec",   OP_I, 1'b1, 4'd2, C_EXEC_MEM);
        cyc("fs.mw0",    OP_I, 1'b0, 4'd4, C_MEMWR_STALL);
        cyc("fs.mw1",    OP_I, 1'b0, 4'd4, C_MEMWR_STALL);
        cyc("fs.mw2",    OP_I, 1'b1, 4'd4, C_MEMWR_DONE);

        // Asynchronous reset while stalled in MEM_WR
        cyc("rw.fetch",  OP_X, 1'b1, 4'd0, C_FETCH_RDY);
        cyc("rw.decode", OP_S, 1'b1, 4'd1, C_DECODE);
        cyc("rw.exec",   OP_S, 1'b1, 4'd2, C_EXEC_MEM);
        cyc("rw.mw0",    OP_S, 1'b0, 4'd4, C_MEMWR_STALL);
        #2;
        rstb         = 1'b0;
        bus.memReady = 1'b1;
        #1;
        push_exp("rw.async", 4'd0, C_ZERO);
        compare_front();
        @(negedge clk);
        push_exp("rw.held", 4'd0, C_ZERO);
        compare_front();
        @(posedge clk);
        #1;
        rstb = 1'b1;
        cyc("rw.r.fetch",  OP_X, 1'b1, 4'd0, C_FETCH_RDY);
        cyc("rw.r.decode", OP_R, 1'b1, 4'd1, C_DECODE);
        cyc("rw.r.exec",   OP_R, 1'b1, 4'd2, C_EXEC_R);
        cyc("rw.r.wb",     OP_R, 1'b1, 4'd5, C_ALUWB);

        // Illegal opcode
        cyc("il.fetch", OP_R, 1'b1, 4'd0, C_FETCH_RDY);
`ifdef PHILV_ILLEGAL_TRAP_EN
        cyc("il.decode", OP_X, 1'b1, 4'd1, C_DECODE);
        for (int i = 0; i < 11; i++) begin
            cyc("il.trap", OP_R, i[0], 4'd7, C_TRAP);
        end
`else
        cyc("il.decode", OP_X, 1'b1, 4'd1, C_DECODE_NOP);
        cyc("il.fetch2",  OP_X, 1'b1, 4'd0, C_FETCH_RDY);
        cyc("il.decode2", OP_I, 1'b1, 4'd1, C_DECODE);
        cyc("il.exec2",   OP_X, 1'b1, 4'd2, C_EXEC_I);
        cyc("il.wb2",     OP_X, 1'b1, 4'd5, C_ALUWB);
`endif

        if (sb_q.size() != 0) begin
            check_val("scoreboard_left", 16'(sb_q.size()), 16'd0);
        end
        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule

// File: doc/multicycle_sequencer.md
# multicycle_sequencer

Multicycle control FSM for the PhilosophyV core. It sequences one instruction at a time through fetch, decode, execute, memory and writeback, and drives the enables and mux selects for the PC, the instruction register, the register file, the ALU source muxes and the shared instruction/data memory port. It replaces single-shot opcode decoding with a stateful controller that stalls on a memory-ready handshake.

## Interface
Parameters:
- `OPCODE_WIDTH`, default 7: width of the RV32 opcode field.
- `STATE_WIDTH`, default 4: width of the state encoding exported on `state`.

Ports:
- `clk`  input  1  single core clock; all state updates on the rising edge.
- `rstb`  input  1  asynchronous active-low reset.
- `opCode`  input  7  `instr[6:0]` from the instruction register; valid from DECODE onward.
- `memReady`  input  1  memory completes the current access this cycle.
- `PCEna`  output  1  PC register load enable.
- `IREna`  output  1  instruction register load enable.
- `IorD`  output  1  memory address select: 0 = PC, 1 = ALU out.
- `memWrite`  output  1  memory write strobe.
- `ALUSrcA`  output  1  0 = PC, 1 = regfile output A.
- `ALUSrcB`  output  2  00 = regfile B, 01 = constant 4, 10 = immediate, 11 = unused.
- `ALUUseFunct`  output  1  1 = ALU function from the funct decoder, 0 = force ADD.
- `regFileWrite`  output  1  register file write enable.
- `memToReg`  output  1  writeback source: 0 = ALU out, 1 = memory data.
- `instrRetired`  output  1  one-cycle pulse on the final cycle of each instruction.
- `trap`  output  1  sticky illegal-opcode flag (see Configuration).
- `state`  output  4  current state, for debug.

## Operation
- The next-state logic registers the state; all other outputs are Moore outputs decoded from the state. `IREna` and `PCEna` are additionally gated by `memReady`.
- State encodings:
  - FETCH = 0
  - DECODE = 1
  - EXEC = 2
  - MEM_RD = 3
  - MEM_WR = 4
  - ALU_WB = 5
  - LOAD_WB = 6
  - TRAP = 7
- FETCH: `IorD` = 0, `ALUSrcA` = 0, `ALUSrcB` = 01, `ALUUseFunct` = 0.
  - `IREna` = `PCEna` = `memReady`.
  - Go to DECODE when `memReady` is high; otherwise hold in FETCH.
- DECODE: all enables low. The register file reads.
  - `opCode` is latched into an internal `op_q`.
  - Next state is EXEC for the legal opcodes 0110011 (R), 0010011 (I-ALU), 0000011 (LOAD) and 0100011 (STORE).
  - Any other opcode goes to the illegal-opcode path (see Configuration).
- EXEC: `ALUSrcA` = 1.
  - R: `ALUSrcB` = 00, `ALUUseFunct` = 1, then ALU_WB.
  - I-ALU: `ALUSrcB` = 10, `ALUUseFunct` = 1, then ALU_WB.
  - LOAD: `ALUSrcB` = 10, `ALUUseFunct` = 0, then MEM_RD.
  - STORE: `ALUSrcB` = 10, `ALUUseFunct` = 0, then MEM_WR.
- MEM_RD: `IorD` = 1. Hold until `memReady`, then go to LOAD_WB.
- MEM_WR: `IorD` = 1, `memWrite` = 1 for every cycle spent in the state. Hold until `memReady`; on that cycle pulse `instrRetired` and go to FETCH.
- ALU_WB: `regFileWrite` = 1, `memToReg` = 0, `instrRetired` = 1, then FETCH.
- LOAD_WB: `regFileWrite` = 1, `memToReg` = 1, `instrRetired` = 1, then FETCH.
- Outputs not listed for a state are 0.

## Timing
- While `rstb` = 0: state = FETCH, `op_q` = 0, `trap` = 0, and every enable/strobe output is forced to 0.
- All mux selects reset to 0.
- The first FETCH access occurs on the first rising edge after `rstb` deasserts.
- Latency with `memReady` tied high, counted FETCH to FETCH:
  - R / I-ALU: 4 cycles.
  - LOAD: 5 cycles.
  - STORE: 4 cycles.
- Each low cycle of `memReady` in FETCH, MEM_RD or MEM_WR adds exactly one cycle. No other state samples `memReady`.
- `PCEna` and `IREna` are high for exactly one cycle per instruction: the FETCH cycle in which `memReady` = 1.
- `regFileWrite` is high for exactly one cycle per R, I-ALU or LOAD instruction. It is never high for STORE.
- An asynchronous reset mid-stall or mid-write drops `memWrite` in the same cycle it asserts. No partial writeback occurs.

## Configuration
- `PHILV_ILLEGAL_TRAP_EN` defined:
  - An illegal opcode in DECODE moves to TRAP and sets `trap` = 1.
  - TRAP holds all enables low and stays in TRAP until reset. `instrRetired` is not pulsed.
- `PHILV_ILLEGAL_TRAP_EN` undefined:
  - An illegal opcode in DECODE is treated as a NOP: `instrRetired` = 1 in that DECODE cycle, then FETCH.
  - `trap` is tied to 0 and TRAP is unreachable.

## Test plan
- Reset then R-type `add`, `memReady` = 1: `state` sequence 0,1,2,5,0. `PCEna` high in cycle 1 only, `regFileWrite` high in cycle 4 only, one `instrRetired` pulse.
- LOAD with `memReady` low for 2 cycles in MEM_RD: sequence 0,1,2,3,3,3,6,0. `IorD` = 1 in all MEM_RD cycles, `memToReg` = 1 in LOAD_WB.
- STORE with `memReady` = 1: sequence 0,1,2,4,0. `memWrite` high for exactly 1 cycle, `regFileWrite` never high.
- FETCH stall of 3 cycles: `PCEna` / `IREna` stay 0 for 3 cycles, then pulse once. `state` holds 0 throughout.
- Opcode 1111111:
  - With `PHILV_ILLEGAL_TRAP_EN` defined, `state` = 7, `trap` = 1, and both hold for 10 further cycles.
  - With it undefined, sequence 0,1,0 and `instrRetired` pulses in DECODE.
- `rstb` pulled low while in MEM_WR: `memWrite` = 0 and `state` = 0 immediately. Normal FETCH resumes after release.
